// File: rtl/custom_instr_pkg.sv
// custom_instr_pkg: opcode, FSM state, queue entry type and popcount helper shared by the CNTB coprocessor
package custom_instr_pkg;
  localparam logic [6:0] OPCODE_CNTB = 7'b0001011;
  localparam int CNTB_RESULT_WIDTH = 6;
  localparam int XIF_ID_WIDTH = 4;
  typedef enum logic [1:0] {IDLE, COUNT, RESULT} cntb_state_e;
  typedef struct packed {
    logic [XIF_ID_WIDTH-1:0] id;
    logic [31:0] rs1;
    logic [4:0] rd;
    logic committed;
    logic killed;
    logic valid;
  } xif_queue_entry_t;
  function automatic logic [CNTB_RESULT_WIDTH-1:0] popcount32(input logic [31:0] v);
    popcount32 = '0;
    for (int i = 0; i < 32; i++) popcount32 = popcount32 + CNTB_RESULT_WIDTH'(v[i]);
  endfunction
endpackage

// File: rtl/custom_cntb_unit.sv
// custom_cntb_unit: iterative popcount of a 32-bit operand, BITS_PER_CYCLE bits per cycle
module custom_cntb_unit
  import custom_instr_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [31:0]                  operand_i,
  output logic                         done_o,
  output logic [CNTB_RESULT_WIDTH-1:0] count_o
);
  localparam int ITERS = 32 / BITS_PER_CYCLE;
  localparam int CW = $clog2(ITERS + 1);
  logic [31:0] sr_q, sr_d;
  logic [CNTB_RESULT_WIDTH-1:0] acc_q, acc_d, slice_cnt;
  logic [CW-1:0] iter_q, iter_d;
  logic active;
  always_comb begin
    slice_cnt = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) slice_cnt = slice_cnt + CNTB_RESULT_WIDTH'(sr_q[i]);
    active = iter_q != '0;
    sr_d = start_i ? operand_i : active ? sr_q >> BITS_PER_CYCLE : sr_q;
    acc_d = start_i ? '0 : active ? acc_q + slice_cnt : acc_q;
    iter_d = start_i ? CW'(ITERS) : active ? iter_q - 1'b1 : iter_q;
  end
  // done marks the final accumulation cycle, so count_o is complete on the following cycle
  assign done_o = iter_q == CW'(1);
  assign count_o = acc_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q <= '0;
      acc_q <= '0;
      iter_q <= '0;
    end else begin
      sr_q <= sr_d;
      acc_q <= acc_d;
      iter_q <= iter_d;
    end
  end
endmodule

// File: rtl/custom_xif_scheduler.sv
// custom_xif_scheduler: XIF issue/commit/result scheduler for CNTB with an in-order queue.
// CUSTOM_XIF_FAST_CNT_EN replaces the iterative COUNT state with a single-cycle popcount.
module custom_xif_scheduler
  import custom_instr_pkg::*;
#(
  parameter int QUEUE_DEPTH    = 4,
  parameter int ID_WIDTH       = XIF_ID_WIDTH,
  parameter int BITS_PER_CYCLE = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_valid_i,
  input  logic [31:0]         issue_instr_i,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  input  logic [31:0]         issue_rs1_i,
  input  logic                issue_rs_valid_i,
  output logic                issue_ready_o,
  output logic                issue_accept_o,
  output logic                issue_writeback_o,
  input  logic                commit_valid_i,
  input  logic [ID_WIDTH-1:0] commit_id_i,
  input  logic                commit_kill_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [ID_WIDTH-1:0] result_id_o,
  output logic [31:0]         result_data_o,
  output logic [4:0]          result_rd_o,
  output logic                result_we_o,
  output logic                busy_o
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  xif_queue_entry_t q_q [QUEUE_DEPTH];
  xif_queue_entry_t q_d [QUEUE_DEPTH];
  xif_queue_entry_t head, new_entry;
  logic [PW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cntb_state_e state_q, state_d;
  logic match, full, empty, push, pop, start, head_hit, head_kill, head_commit;
  logic [CNTB_RESULT_WIDTH-1:0] cnt_value;
  assign match = issue_instr_i[6:0] == OPCODE_CNTB;
  assign empty = wr_ptr_q == rd_ptr_q;
  assign full = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign issue_ready_o = !full && (!match || issue_rs_valid_i);
  assign issue_accept_o = match;
  assign issue_writeback_o = match;
  assign push = issue_valid_i && issue_ready_o && match;
  assign head = q_q[rd_ptr_q[PW-1:0]];
  // A commit/kill aimed at the head is acted on in the same cycle it arrives
  assign head_hit = commit_valid_i && head.id[ID_WIDTH-1:0] == commit_id_i;
  assign head_kill = head.valid && (head.killed || (head_hit && commit_kill_i));
  assign head_commit = head.valid && !head_kill && (head.committed || (head_hit && !commit_kill_i));
  always_comb begin
    new_entry = '0;
    new_entry.id[ID_WIDTH-1:0] = issue_id_i;
    new_entry.rs1 = issue_rs1_i;
    new_entry.rd = issue_instr_i[11:7];
    new_entry.valid = 1'b1;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      q_d[i] = q_q[i];
      if (commit_valid_i && q_q[i].valid && q_q[i].id[ID_WIDTH-1:0] == commit_id_i) begin
        q_d[i].killed = q_q[i].killed | commit_kill_i;
        q_d[i].committed = q_q[i].committed | !commit_kill_i;
      end
    end
    if (pop) q_d[rd_ptr_q[PW-1:0]] = '0;
    if (push) q_d[wr_ptr_q[PW-1:0]] = new_entry;
    rd_ptr_d = rd_ptr_q + (PW+1)'(pop);
    wr_ptr_d = wr_ptr_q + (PW+1)'(push);
  end
`ifdef CUSTOM_XIF_FAST_CNT_EN
  localparam cntb_state_e DISPATCH_STATE = RESULT;
  logic [CNTB_RESULT_WIDTH-1:0] res_q, res_d;
  assign res_d = start ? popcount32(head.rs1) : res_q;
  assign cnt_value = res_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) res_q <= '0;
    else res_q <= res_d;
  end
`else
  localparam cntb_state_e DISPATCH_STATE = COUNT;
  logic cnt_done;
  custom_cntb_unit #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_cntb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start),
    .operand_i (head.rs1),
    .done_o    (cnt_done),
    .count_o   (cnt_value)
  );
`endif
  always_comb begin
    state_d = state_q;
    pop = 1'b0;
    start = 1'b0;
    case (state_q)
      IDLE: begin
        pop = head_kill;
        start = head_commit;
        state_d = head_commit ? DISPATCH_STATE : IDLE;
      end
`ifndef CUSTOM_XIF_FAST_CNT_EN
      COUNT: state_d = cnt_done ? RESULT : COUNT;
`endif
      RESULT: begin
        pop = result_ready_i;
        state_d = result_ready_i ? IDLE : RESULT;
      end
      default: state_d = IDLE;
    endcase
  end
  assign result_valid_o = state_q == RESULT;
  assign result_id_o = result_valid_o ? head.id[ID_WIDTH-1:0] : '0;
  assign result_data_o = result_valid_o ? 32'(cnt_value) : '0;
  assign result_rd_o = result_valid_o ? head.rd : '0;
  assign result_we_o = result_valid_o;
  assign busy_o = !empty || state_q != IDLE;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) q_q[i] <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      q_q <= q_d;
    end
  end
  // Commit must trail issue, and the dispatched head may not be killed
  assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && commit_valid_i && commit_id_i == issue_id_i));
  assert property (@(posedge clk_i) disable iff (rst_i)
    !(commit_valid_i && commit_kill_i && state_q != IDLE && commit_id_i == head.id[ID_WIDTH-1:0]));
endmodule

// File: tb/tb_custom_xif_scheduler.sv
// tb_custom_xif_scheduler: table-driven and directed checks of the CNTB XIF scheduler
module tb_custom_xif_scheduler;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic issue_valid_i = 1'b0;
  logic [31:0] issue_instr_i = '0;
  logic [3:0] issue_id_i = '0;
  logic [31:0] issue_rs1_i = '0;
  logic issue_rs_valid_i = 1'b0;
  logic issue_ready_o, issue_accept_o, issue_writeback_o;
  logic commit_valid_i = 1'b0;
  logic [3:0] commit_id_i = '0;
  logic commit_kill_i = 1'b0;
  logic result_valid_o;
  logic result_ready_i = 1'b1;
  logic [3:0] result_id_o;
  logic [31:0] result_data_o;
  logic [4:0] result_rd_o;
  logic result_we_o, busy_o;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  localparam logic [6:0] OP = 7'h0B;
`ifdef CUSTOM_XIF_FAST_CNT_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 5;
`endif

  custom_xif_scheduler dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
    .issue_rs1_i(issue_rs1_i), .issue_rs_valid_i(issue_rs_valid_i),
    .issue_ready_o(issue_ready_o), .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i), .result_id_o(result_id_o),
    .result_data_o(result_data_o), .result_rd_o(result_rd_o), .result_we_o(result_we_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  typedef struct {
    logic valid;
    logic [31:0] instr;
    logic rs_valid;
    logic ready;
    logic accept;
    logic wb;
  } dec_vec_t;

  typedef struct {
    logic [3:0] id;
    logic [31:0] rs1;
    logic [4:0] rd;
    logic [31:0] data;
  } cnt_vec_t;

  dec_vec_t dv[5];
  cnt_vec_t cv[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [3:0] id, input logic [31:0] rs1, input logic [4:0] rd);
    issue_valid_i = 1'b1;
    issue_instr_i = {20'h0, rd, OP};
    issue_id_i = id;
    issue_rs1_i = rs1;
    issue_rs_valid_i = 1'b1;
    #1;
    chk("issue_ready", 32'(issue_ready_o), 1);
    @(posedge clk_i);
    #1;
    issue_valid_i = 1'b0;
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    commit_valid_i = 1'b1;
    commit_id_i = id;
    commit_kill_i = kill;
    tick;
    commit_valid_i = 1'b0;
  endtask

  task automatic wait_result(input logic [3:0] id, input logic [31:0] data, input logic [4:0] rd,
                             input int c0, input bit check_lat);
    int n = 0;
    @(negedge clk_i);
    while (!result_valid_o && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    if (result_valid_o) begin
      if (check_lat) chk("latency", 32'(cyc - c0), 32'(LAT));
      chk("result_id", 32'(result_id_o), 32'(id));
      chk("result_data", result_data_o, data);
      chk("result_rd", 32'(result_rd_o), 32'(rd));
      chk("result_we", 32'(result_we_o), 1);
    end else begin
      chk("result_timeout", 0, 1);
    end
  endtask

  task automatic no_result(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_i);
      if (result_valid_o) seen++;
    end
    chk(name, 32'(seen), 0);
  endtask

  initial begin
    int c0;
    dv[0] = '{1'b1, 32'h0000_0033, 1'b0, 1'b1, 1'b0, 1'b0};
    dv[1] = '{1'b1, 32'h00A0_0013, 1'b1, 1'b1, 1'b0, 1'b0};
    dv[2] = '{1'b1, 32'h0000_008B, 1'b0, 1'b0, 1'b1, 1'b1};
    dv[3] = '{1'b0, 32'h0000_058B, 1'b1, 1'b1, 1'b1, 1'b1};
    dv[4] = '{1'b1, 32'h0000_007F, 1'b0, 1'b1, 1'b0, 1'b0};
    cv[0] = '{4'd2,  32'hF0F0_00FF, 5'd5,  32'd16};
    cv[1] = '{4'd7,  32'hFFFF_FFFF, 5'd31, 32'd32};
    cv[2] = '{4'd0,  32'h0000_0000, 5'd0,  32'd0};
    cv[3] = '{4'd9,  32'h8000_0001, 5'd17, 32'd2};
    cv[4] = '{4'd12, 32'h1234_5678, 5'd10, 32'd13};
    cv[5] = '{4'd15, 32'hAAAA_AAAA, 5'd1,  32'd16};

    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk("rst_issue_ready", 32'(issue_ready_o), 1);
    chk("rst_result_valid", 32'(result_valid_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_accept", 32'(issue_accept_o), 0);
    chk("rst_result_data", result_data_o, 0);

    for (int i = 0; i < 5; i++) begin
      issue_valid_i = dv[i].valid;
      issue_instr_i = dv[i].instr;
      issue_rs_valid_i = dv[i].rs_valid;
      issue_id_i = 4'(i);
      #1;
      chk($sformatf("dec%0d_ready", i), 32'(issue_ready_o), 32'(dv[i].ready));
      chk($sformatf("dec%0d_accept", i), 32'(issue_accept_o), 32'(dv[i].accept));
      chk($sformatf("dec%0d_wb", i), 32'(issue_writeback_o), 32'(dv[i].wb));
      tick;
      issue_valid_i = 1'b0;
      chk($sformatf("dec%0d_busy", i), 32'(busy_o), 0);
    end

    for (int i = 0; i < 6; i++) begin
      issue(cv[i].id, cv[i].rs1, cv[i].rd);
      c0 = cyc;
      commit(cv[i].id, 1'b0);
      wait_result(cv[i].id, cv[i].data, cv[i].rd, c0, 1'b1);
      tick;
      chk($sformatf("cnt%0d_busy_after", i), 32'(busy_o), 0);
    end

    issue(4'd1, 32'hFFFF_FFFF, 5'd3);
    issue(4'd2, 32'h1234_5678, 5'd4);
    issue(4'd3, 32'h0000_0000, 5'd5);
    commit(4'd2, 1'b1);
    commit(4'd3, 1'b0);
    c0 = cyc;
    commit(4'd1, 1'b0);
    wait_result(4'd1, 32'd32, 5'd3, c0, 1'b1);
    tick;
    wait_result(4'd3, 32'd0, 5'd5, 0, 1'b0);
    tick;
    no_result("kill_no_extra_result", 12);
    chk("kill_busy", 32'(busy_o), 0);

    result_ready_i = 1'b0;
    issue(4'd0, 32'h0000_000F, 5'd8);
    issue(4'd1, 32'h0000_00FF, 5'd9);
    issue(4'd2, 32'h0000_0FFF, 5'd10);
    issue(4'd3, 32'h0000_FFFF, 5'd11);
    issue_valid_i = 1'b1;
    issue_instr_i = {20'h0, 5'd12, OP};
    issue_id_i = 4'd5;
    issue_rs_valid_i = 1'b1;
    #1;
    chk("full_ready_cntb", 32'(issue_ready_o), 0);
    tick;
    issue_valid_i = 1'b0;
    issue_instr_i = 32'h0000_0033;
    #1;
    chk("full_ready_other", 32'(issue_ready_o), 0);
    c0 = cyc;
    commit(4'd0, 1'b0);
    wait_result(4'd0, 32'd4, 5'd8, c0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("hold%0d_valid", i), 32'(result_valid_o), 1);
      chk($sformatf("hold%0d_data", i), result_data_o, 32'd4);
      chk($sformatf("hold%0d_id", i), 32'(result_id_o), 0);
    end
    issue_instr_i = {20'h0, 5'd12, OP};
    issue_rs_valid_i = 1'b1;
    #1;
    chk("hold_ready_still_full", 32'(issue_ready_o), 0);
    result_ready_i = 1'b1;
    tick;
    chk("pop_ready", 32'(issue_ready_o), 1);
    chk("pop_busy", 32'(busy_o), 1);
    chk("pop_result_valid", 32'(result_valid_o), 0);
    commit(4'd1, 1'b1);
    commit(4'd2, 1'b1);
    commit(4'd3, 1'b1);
    chk("drain_busy", 32'(busy_o), 0);

    issue(4'd9, 32'hFFFF_FFFF, 5'd2);
    commit(4'd9, 1'b0);
    tick;
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    chk("midrst_result_valid", 32'(result_valid_o), 0);
    chk("midrst_busy", 32'(busy_o), 0);
    chk("midrst_ready", 32'(issue_ready_o), 1);
    no_result("midrst_no_result", 10);

    issue(4'd4, 32'h0F0F_0F0F, 5'd6);
    c0 = cyc;
    commit(4'd4, 1'b0);
    wait_result(4'd4, 32'd16, 5'd6, c0, 1'b1);
    tick;
    chk("final_busy", 32'(busy_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/custom_xif_scheduler.md
Name: custom_xif_scheduler

Overview:
- Issue/commit/result scheduler for the custom coprocessor on the core's eXtension interface (CV32E40X XIF).
- Decodes and accepts OPCODE_CNTB (count set bits of rs1) instructions, buffers them in an in-order queue and tracks commit/kill per instruction ID.
- Sequences an iterative bit-count unit for each committed instruction and returns results through a valid/ready result handshake.

Parameters:
- QUEUE_DEPTH, 4, number of outstanding instructions; power of two, at least 2.
- ID_WIDTH, 4, width of the XIF instruction ID.
- BITS_PER_CYCLE, 8, rs1 bits counted per COUNT cycle; must divide 32.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- issue_valid_i  in  1  issue request valid.
- issue_instr_i  in  32  instruction word.
- issue_id_i  in  ID_WIDTH  instruction ID.
- issue_rs1_i  in  32  rs1 operand.
- issue_rs_valid_i  in  1  rs1 operand valid.
- issue_ready_o  out  1  issue handshake ready.
- issue_accept_o  out  1  instruction accepted by the coprocessor.
- issue_writeback_o  out  1  accepted instruction writes rd.
- commit_valid_i  in  1  commit message valid.
- commit_id_i  in  ID_WIDTH  ID being committed or killed.
- commit_kill_i  in  1  1 = kill, 0 = commit.
- result_valid_o  out  1  result valid.
- result_ready_i  in  1  core accepts result.
- result_id_o  out  ID_WIDTH  result ID.
- result_data_o  out  32  bit count, zero-extended.
- result_rd_o  out  5  destination register (instr[11:7]).
- result_we_o  out  1  register write enable.
- busy_o  out  1  queue non-empty or FSM not IDLE.

Behaviour:
- Reset: queue empty, FSM in IDLE, all outputs 0 except issue_ready_o, which is 1 in the cycle after rst_i deasserts. Reset mid-operation discards all entries and any in-flight count.
- Issue decode is combinational: match = (instr[6:0] == OPCODE_CNTB).
- issue_ready_o = !full && (!match || issue_rs_valid_i). Unknown opcodes complete the handshake with accept = 0 and writeback = 0.
- issue_accept_o = issue_writeback_o = match.
- Enqueue on issue_valid_i && issue_ready_o && match. Entry fields: {id, rs1, rd, committed = 0, killed = 0}.
- Commit handling: all valid entries with a matching id are updated. kill sets killed; commit sets committed.
  - IDs that match no entry are ignored.
  - A commit for an ID issued in the same cycle is a protocol violation (assertion).
- Queue pointers are circular, with wrap-around at QUEUE_DEPTH. Full/empty are derived from an extra pointer bit.
- An enqueue and a pop in the same cycle are allowed; occupancy is unchanged. When full there is no bypass: issue_ready_o = 0 for matching instructions.
- FSM:
  - IDLE: if head is valid and killed, pop and stay in IDLE (one cycle per killed entry). If head is valid and committed, load rs1 into the shift register, clear the accumulator, go to COUNT. Otherwise stay.
  - COUNT: each cycle adds popcount(sr[BITS_PER_CYCLE-1:0]) to a 6-bit accumulator and shifts sr right by BITS_PER_CYCLE. After 32/BITS_PER_CYCLE cycles, go to RESULT.
  - RESULT: result_valid_o = 1; id, data, rd and we (= 1) are stable until result_ready_i. On handshake, pop head and go to IDLE.
- Latency: head committed in IDLE at cycle n gives result_valid_o at n+1+32/BITS_PER_CYCLE (default n+5).
- Dispatch happens only after commit, so in-flight instructions are never killed. A kill arriving for the head's ID while in COUNT or RESULT is an assertion failure.
- result_valid_o never deasserts without a handshake. Results are returned strictly in issue order.

Optional Feature:
- Macro: CUSTOM_XIF_FAST_CNT_EN.
- Defined: COUNT state removed. IDLE computes the full 32-bit popcount in one step and goes directly to RESULT; latency is n+1.
- Undefined: iterative COUNT behaviour as specified above.

Decomposition:
- custom_instr_pkg gains:
  - cntb_state_e {IDLE, COUNT, RESULT};
  - xif_queue_entry_t struct {id, rs1, rd, committed, killed, valid};
  - CNTB_RESULT_WIDTH = 6.
  OPCODE_CNTB remains defined in custom_instr_pkg.
- One sub-module: custom_cntb_unit, holding the shift register, accumulator, iteration counter and done pulse; start/operand in, done/count out. The queue and FSM stay in the top.

Test Plan:
- Issue CNTB id=2, rs1=0xF0F000FF; commit id=2 at cycle 10 -> result_valid_o at cycle 15, data=16, rd=instr[11:7], we=1.
- Issue a non-CNTB opcode (0x33) -> issue_ready_o=1, accept=0, writeback=0; busy_o stays 0.
- Issue ids 1,2,3; kill id=2; commit ids 1 and 3; rs1=0xFFFFFFFF, 0x0 -> results id=1 data=32, then id=3 data=0; no result for id 2.
- Fill 4 entries without commit -> issue_ready_o=0 for CNTB; commit id0, hold result_ready_i=0 for 3 cycles -> result stable; on handshake, pop and issue_ready_o=1 next cycle.
- Assert rst_i during COUNT -> next cycle queue empty, FSM IDLE, result_valid_o=0, busy_o=0.
- With CUSTOM_XIF_FAST_CNT_EN, rs1=0x80000001 committed at cycle n -> result_valid_o at n+1, data=2.
